// File: rtl/bitwise_logic_unit.sv
// bitwise_logic_unit: registered WIDTH-bit bitwise ALU with eight operations,
// an accumulate mode that folds a burst of beats into one result, and
// valid/ready handshakes on the input and output sides.
//
// Optional feature macro: BITWISE_LOGIC_UNIT_PARITY_EN adds the y_parity
// output (^y, registered with y). When undefined, that port does not exist.
//
// Handshake semantics (both sides): a transfer happens on a rising edge where
// valid && ready are both high. A producer holding valid keeps its payload
// stable until the transfer. in_ready = !out_valid || out_ready, so the unit
// accepts a new beat whenever the output register is empty or is being
// drained on the same edge. in_ready never depends on in_valid.
module bitwise_logic_unit #(
    parameter int WIDTH = 8,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [2:0]       op,
    input  logic             acc,
    input  logic             last,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] y,
    output logic             y_zero,
    output logic             y_ones,
`ifdef BITWISE_LOGIC_UNIT_PARITY_EN
    output logic             y_parity,
`endif
    output logic [CNT_W-1:0] y_count
);

    localparam logic [2:0] OP_AND  = 3'd0;
    localparam logic [2:0] OP_OR   = 3'd1;
    localparam logic [2:0] OP_XOR  = 3'd2;
    localparam logic [2:0] OP_NAND = 3'd3;
    localparam logic [2:0] OP_NOR  = 3'd4;
    localparam logic [2:0] OP_XNOR = 3'd5;
    localparam logic [2:0] OP_ANDN = 3'd6;
    localparam logic [2:0] OP_PASS = 3'd7;

    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic [WIDTH-1:0] r_acc_reg;
    logic             r_acc_open;
    logic [CNT_W-1:0] r_beat_cnt;
    logic             r_out_valid;
    logic [WIDTH-1:0] r_y;
    logic             r_y_zero;
    logic             r_y_ones;
    logic [CNT_W-1:0] r_y_count;
`ifdef BITWISE_LOGIC_UNIT_PARITY_EN
    logic             r_y_parity;
`endif

    logic             w_accept;
    logic             w_produce;
    logic             w_continue;
    logic [WIDTH-1:0] w_x;
    logic [WIDTH-1:0] w_r;
    logic [CNT_W-1:0] w_cnt_next;

    assign in_ready   = !r_out_valid || out_ready;
    assign w_accept   = in_valid && in_ready;
    // A standalone beat or the closing beat of a burst loads the output.
    assign w_produce  = !acc || last;
    // Mid-burst beats extend the open burst (or start one).
    assign w_continue = acc && !last;

    // Inside an open burst the running value replaces operand A.
    assign w_x = (acc && r_acc_open) ? r_acc_reg : a;

    // Beat count including the current beat; restarts at 1 for a new burst
    // and sticks at the maximum once saturated.
    assign w_cnt_next = !r_acc_open           ? CNT_ONE :
                        (r_beat_cnt == CNT_MAX) ? r_beat_cnt :
                        r_beat_cnt + CNT_ONE;

    // Bitwise operation selected per beat.
    always_comb begin
        w_r = '0;
        case (op)
            OP_AND:  w_r = w_x & b;
            OP_OR:   w_r = w_x | b;
            OP_XOR:  w_r = w_x ^ b;
            OP_NAND: w_r = ~(w_x & b);
            OP_NOR:  w_r = ~(w_x | b);
            OP_XNOR: w_r = ~(w_x ^ b);
            OP_ANDN: w_r = w_x & ~b;
            OP_PASS: w_r = w_x;
            default: w_r = '0;
        endcase
    end

    // Burst state: running value, open flag and beat counter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_acc_reg  <= '0;
            r_acc_open <= 1'b0;
            r_beat_cnt <= '0;
        end else if (w_accept) begin
            if (w_continue) begin
                r_acc_reg  <= w_r;
                r_acc_open <= 1'b1;
                r_beat_cnt <= w_cnt_next;
            end else begin
                // Burst closed by last, or discarded by a standalone beat.
                r_acc_open <= 1'b0;
                r_beat_cnt <= '0;
            end
        end
    end

    // Output register: loads on producing beats, drains on out_ready,
    // otherwise holds every field stable.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_out_valid <= 1'b0;
            r_y         <= '0;
            r_y_zero    <= 1'b0;
            r_y_ones    <= 1'b0;
            r_y_count   <= '0;
`ifdef BITWISE_LOGIC_UNIT_PARITY_EN
            r_y_parity  <= 1'b0;
`endif
        end else if (w_accept && w_produce) begin
            r_out_valid <= 1'b1;
            r_y         <= w_r;
            r_y_zero    <= ~|w_r;
            r_y_ones    <= &w_r;
            r_y_count   <= acc ? w_cnt_next : CNT_ONE;
`ifdef BITWISE_LOGIC_UNIT_PARITY_EN
            r_y_parity  <= ^w_r;
`endif
        end else if (out_ready) begin
            r_out_valid <= 1'b0;
        end
    end

    assign out_valid = r_out_valid;
    assign y         = r_y;
    assign y_zero    = r_y_zero;
    assign y_ones    = r_y_ones;
    assign y_count   = r_y_count;
`ifdef BITWISE_LOGIC_UNIT_PARITY_EN
    assign y_parity  = r_y_parity;
`endif

endmodule

// File: tb/tb_bitwise_logic_unit.sv
// Directed testbench for bitwise_logic_unit. Two instances share the input
// stimulus: u_dut (WIDTH=8, CNT_W=8) and u_sat (WIDTH=8, CNT_W=2) for the
// counter saturation case.
module tb_bitwise_logic_unit;

    logic       clk;
    logic       rst_n;
    logic       in_valid;
    logic [7:0] a;
    logic [7:0] b;
    logic [2:0] op;
    logic       acc;
    logic       last;
    logic       out_ready;

    logic       in_ready;
    logic       out_valid;
    logic [7:0] y;
    logic       y_zero;
    logic       y_ones;
    logic [7:0] y_count;

    logic       s_in_ready;
    logic       s_out_valid;
    logic [7:0] s_y;
    logic       s_y_zero;
    logic       s_y_ones;
    logic [1:0] s_y_count;

`ifdef BITWISE_LOGIC_UNIT_PARITY_EN
    logic       y_parity;
    logic       s_y_parity;
`endif

    int pass_cnt = 0;
    int total_cnt = 0;

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    bitwise_logic_unit #(.WIDTH(8), .CNT_W(8)) u_dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .op(op), .acc(acc), .last(last),
        .out_valid(out_valid), .out_ready(out_ready), .y(y),
        .y_zero(y_zero), .y_ones(y_ones),
`ifdef BITWISE_LOGIC_UNIT_PARITY_EN
        .y_parity(y_parity),
`endif
        .y_count(y_count)
    );

    bitwise_logic_unit #(.WIDTH(8), .CNT_W(2)) u_sat (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(s_in_ready),
        .a(a), .b(b), .op(op), .acc(acc), .last(last),
        .out_valid(s_out_valid), .out_ready(out_ready), .y(s_y),
        .y_zero(s_y_zero), .y_ones(s_y_ones),
`ifdef BITWISE_LOGIC_UNIT_PARITY_EN
        .y_parity(s_y_parity),
`endif
        .y_count(s_y_count)
    );

    // driver tasks
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [7:0] ta, input logic [7:0] tb,
                         input logic [2:0] top, input logic tacc, input logic tlast);
        in_valid = v;
        a        = ta;
        b        = tb;
        op       = top;
        acc      = tacc;
        last     = tlast;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        out_ready = 1'b1;
        drive(1'b0, 8'h00, 8'h00, 3'd0, 1'b0, 1'b0);
        #12;
        rst_n = 1'b1;
        step();
        total_cnt++;
        if (out_valid !== 1'b0) $display("FAIL reset_out_valid got %0b want 0", out_valid);
        else pass_cnt++;
        total_cnt++;
        if (y !== 8'h00 || y_zero !== 1'b0 || y_ones !== 1'b0 || y_count !== 8'd0)
            $display("FAIL reset_outputs got y=%h z=%b o=%b cnt=%0d want 00/0/0/0",
                     y, y_zero, y_ones, y_count);
        else pass_cnt++;
        total_cnt++;
        if (in_ready !== 1'b1) $display("FAIL reset_in_ready got %0b want 1", in_ready);
        else pass_cnt++;
    endtask

    // all eight ops back to back, out_ready held high
    task automatic test_ops();
        logic [7:0] exp_y [8];
        exp_y = '{8'h0A, 8'hCF, 8'hC5, 8'hF5, 8'h30, 8'h3A, 8'hC0, 8'hCA};
        out_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            drive(1'b1, 8'hCA, 8'h0F, 3'(i), 1'b0, 1'b0);
            step();
            total_cnt++;
            if (out_valid !== 1'b1 || y !== exp_y[i] || y_count !== 8'd1)
                $display("FAIL op_%0d got v=%b y=%h cnt=%0d want v=1 y=%h cnt=1",
                         i, out_valid, y, y_count, exp_y[i]);
            else pass_cnt++;
        end
        drive(1'b0, 8'h00, 8'h00, 3'd0, 1'b0, 1'b0);
        step();
        total_cnt++;
        if (out_valid !== 1'b0) $display("FAIL ops_drain got %0b want 0", out_valid);
        else pass_cnt++;
    endtask

    task automatic test_flags();
        drive(1'b1, 8'hFF, 8'hFF, 3'd0, 1'b0, 1'b0);
        step();
        total_cnt++;
        if (y !== 8'hFF || y_ones !== 1'b1 || y_zero !== 1'b0)
            $display("FAIL flags_ones got y=%h o=%b z=%b want FF/1/0", y, y_ones, y_zero);
        else pass_cnt++;
        drive(1'b1, 8'hFF, 8'hFF, 3'd2, 1'b0, 1'b0);
        step();
        total_cnt++;
        if (y !== 8'h00 || y_zero !== 1'b1 || y_ones !== 1'b0)
            $display("FAIL flags_zero got y=%h z=%b o=%b want 00/1/0", y, y_zero, y_ones);
        else pass_cnt++;
        drive(1'b0, 8'h00, 8'h00, 3'd0, 1'b0, 1'b0);
        step();
    endtask

    task automatic test_accumulate();
        drive(1'b1, 8'hFF, 8'hF0, 3'd0, 1'b1, 1'b0);
        step();
        total_cnt++;
        if (out_valid !== 1'b0) $display("FAIL acc_beat1_valid got %0b want 0", out_valid);
        else pass_cnt++;
        // a deliberately zero: the burst must use the running value instead
        drive(1'b1, 8'h00, 8'h3C, 3'd0, 1'b1, 1'b0);
        step();
        total_cnt++;
        if (out_valid !== 1'b0) $display("FAIL acc_beat2_valid got %0b want 0", out_valid);
        else pass_cnt++;
        drive(1'b1, 8'h00, 8'h18, 3'd0, 1'b1, 1'b1);
        step();
        total_cnt++;
        if (out_valid !== 1'b1 || y !== 8'h10 || y_count !== 8'd3)
            $display("FAIL acc_result got v=%b y=%h cnt=%0d want v=1 y=10 cnt=3",
                     out_valid, y, y_count);
        else pass_cnt++;
        drive(1'b0, 8'h00, 8'h00, 3'd0, 1'b0, 1'b0);
        step();
        total_cnt++;
        if (out_valid !== 1'b0) $display("FAIL acc_single_output got %0b want 0", out_valid);
        else pass_cnt++;
    endtask

    task automatic test_backpressure();
        int bad;
        out_ready = 1'b0;
        drive(1'b1, 8'hCA, 8'h0F, 3'd1, 1'b0, 1'b0);
        step();
        total_cnt++;
        if (out_valid !== 1'b1 || y !== 8'hCF)
            $display("FAIL bp_load got v=%b y=%h want v=1 y=CF", out_valid, y);
        else pass_cnt++;
        // next beat waits: a mid-burst beat first, which must not be taken
        drive(1'b1, 8'hCA, 8'h0F, 3'd0, 1'b1, 1'b0);
        bad = 0;
        for (int i = 0; i < 5; i++) begin
            if (in_ready !== 1'b0 || out_valid !== 1'b1 || y !== 8'hCF || y_count !== 8'd1)
                bad++;
            step();
        end
        total_cnt++;
        if (bad != 0)
            $display("FAIL bp_stall got %0d bad cycles (ir=%b v=%b y=%h) want 0",
                     bad, in_ready, out_valid, y);
        else pass_cnt++;
        drive(1'b1, 8'hCA, 8'h0F, 3'd0, 1'b0, 1'b0);
        out_ready = 1'b1;
        #1;
        total_cnt++;
        if (in_ready !== 1'b1) $display("FAIL bp_release_ready got %0b want 1", in_ready);
        else pass_cnt++;
        step();
        total_cnt++;
        if (out_valid !== 1'b1 || y !== 8'h0A || y_count !== 8'd1)
            $display("FAIL bp_no_bubble got v=%b y=%h cnt=%0d want v=1 y=0A cnt=1",
                     out_valid, y, y_count);
        else pass_cnt++;
        drive(1'b0, 8'h00, 8'h00, 3'd0, 1'b0, 1'b0);
        step();
    endtask

    task automatic test_reset_mid_burst();
        drive(1'b1, 8'hCA, 8'h0F, 3'd1, 1'b0, 1'b0);
        step();
        drive(1'b1, 8'hF0, 8'h0F, 3'd1, 1'b1, 1'b0);
        step();
        drive(1'b1, 8'h00, 8'h00, 3'd1, 1'b1, 1'b0);
        step();
        drive(1'b0, 8'h00, 8'h00, 3'd0, 1'b0, 1'b0);
        rst_n = 1'b0;
        #1;
        total_cnt++;
        if (out_valid !== 1'b0 || y !== 8'h00 || y_count !== 8'd0 || in_ready !== 1'b1)
            $display("FAIL rst_async got v=%b y=%h cnt=%0d ir=%b want 0/00/0/1",
                     out_valid, y, y_count, in_ready);
        else pass_cnt++;
        #1;
        rst_n = 1'b1;
        drive(1'b1, 8'h01, 8'h02, 3'd1, 1'b1, 1'b1);
        step();
        total_cnt++;
        if (out_valid !== 1'b1 || y !== 8'h03 || y_count !== 8'd1)
            $display("FAIL rst_new_burst got v=%b y=%h cnt=%0d want v=1 y=03 cnt=1",
                     out_valid, y, y_count);
        else pass_cnt++;
        drive(1'b0, 8'h00, 8'h00, 3'd0, 1'b0, 1'b0);
        step();
    endtask

    task automatic test_saturation_abort();
        logic [7:0] bvec [5];
        bvec = '{8'hFF, 8'hFE, 8'hFC, 8'hF8, 8'hF0};
        for (int i = 0; i < 5; i++) begin
            drive(1'b1, 8'hFF, bvec[i], 3'd0, 1'b1, (i == 4));
            step();
        end
        total_cnt++;
        if (s_out_valid !== 1'b1 || s_y !== 8'hF0 || s_y_count !== 2'd3)
            $display("FAIL sat_cnt2 got v=%b y=%h cnt=%0d want v=1 y=F0 cnt=3",
                     s_out_valid, s_y, s_y_count);
        else pass_cnt++;
        total_cnt++;
        if (y !== 8'hF0 || y_count !== 8'd5)
            $display("FAIL sat_cnt8 got y=%h cnt=%0d want y=F0 cnt=5", y, y_count);
        else pass_cnt++;
        // open a burst, then abort it with a standalone beat
        drive(1'b1, 8'h0F, 8'hFF, 3'd0, 1'b1, 1'b0);
        step();
        drive(1'b1, 8'h33, 8'h0F, 3'd1, 1'b0, 1'b0);
        step();
        total_cnt++;
        if (out_valid !== 1'b1 || y !== 8'h3F || y_count !== 8'd1)
            $display("FAIL abort_standalone got v=%b y=%h cnt=%0d want v=1 y=3F cnt=1",
                     out_valid, y, y_count);
        else pass_cnt++;
        drive(1'b1, 8'h55, 8'hFF, 3'd0, 1'b1, 1'b1);
        step();
        total_cnt++;
        if (out_valid !== 1'b1 || y !== 8'h55 || y_count !== 8'd1)
            $display("FAIL abort_uses_a got v=%b y=%h cnt=%0d want v=1 y=55 cnt=1",
                     out_valid, y, y_count);
        else pass_cnt++;
        drive(1'b0, 8'h00, 8'h00, 3'd0, 1'b0, 1'b0);
        step();
    endtask

    // sequence and final report
    initial begin
        test_reset();
        test_ops();
        test_flags();
        test_accumulate();
        test_backpressure();
        test_reset_mid_burst();
        test_saturation_abort();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule

// File: doc/bitwise_logic_unit.md
# bitwise_logic_unit

Parametrised, registered bitwise logic unit: the multi-bit, multi-operation successor of the 2-input AND gate used in the coverage examples. It applies one of eight selectable bitwise operations to two WIDTH-bit operands. It supports an accumulate mode that folds a burst of beats into one result, and moves data through valid/ready handshakes on both sides. It serves as the DUT for functional-coverage exercises: operation cross, accumulate bursts and backpressure.

## Interface
- WIDTH, 8: operand and result width in bits (≥1).
- CNT_W, 8: width of the beat counter (≥1).
- clk  input  1  rising-edge clock.
- rst_n  input  1  reset, asynchronous assert, active-low.
- in_valid  input  1  input beat present.
- in_ready  output  1  unit accepts a beat this cycle.
- a  input  WIDTH  operand A.
- b  input  WIDTH  operand B.
- op  input  3  operation: 0 AND, 1 OR, 2 XOR, 3 NAND, 4 NOR, 5 XNOR, 6 ANDN (A & ~B), 7 PASS_A.
- acc  input  1  beat belongs to an accumulation burst.
- last  input  1  final beat of a burst; ignored when acc=0.
- out_valid  output  1  result present.
- out_ready  input  1  downstream accepts the result.
- y  output  WIDTH  result.
- y_zero  output  1  y is all zeros.
- y_ones  output  1  y is all ones.
- y_count  output  CNT_W  number of beats folded into y; saturates at 2^CNT_W−1.

## Operation
- Accept condition: in_valid && in_ready, where in_ready = !out_valid || out_ready.
- Internal state: acc_reg[WIDTH], acc_open, beat_cnt[CNT_W], and the output register (out_valid, y, flags, y_count).
- Operand X: X = acc_reg when acc=1 && acc_open=1; otherwise X = a. Result R = X op b. For PASS_A, R = X.
- Standalone beat (acc=0):
  - Output loads R and y_count=1.
  - acc_open clears and any open burst is discarded.
- Accumulate beat, acc=1 && last=0:
  - acc_reg←R, acc_open←1.
  - beat_cnt←1 if acc_open was 0, else beat_cnt+1 (saturating).
  - No output is produced.
- Accumulate beat, acc=1 && last=1:
  - Output loads R and y_count = final beat count (1 if acc_open was 0).
  - acc_open←0 and beat_cnt←0.
- Each beat uses its own op, so mixed operations within a burst are legal.
- y_zero, y_ones and y_count are registered together with y.
- All of them hold stable while out_valid=1 && out_ready=0.
- Output handshake: out_valid clears on out_ready unless a new result loads in the same cycle.

## Timing
- Reset values: out_valid=0, y=0, y_zero=0, y_ones=0, y_count=0, acc_reg=0, acc_open=0, beat_cnt=0. in_ready=1 follows from out_valid=0.
- Latency: an output-producing beat accepted at edge N has out_valid=1 and y valid after edge N.
- Throughput is 1 beat/cycle while out_ready=1.
- Backpressure:
  - While out_valid=1 && out_ready=0, in_ready=0, so no beat is accepted, including non-output accumulate beats.
  - Simultaneous out_ready=1 and a new accept replaces the output in one edge with no bubble.
- in_ready is combinational from out_valid and out_ready only, with no path from in_valid.
- Reset mid-burst: the asynchronous assert clears all state immediately. The next acc beat starts a new burst with X=a.
- Counter saturation: beat_cnt stops at 2^CNT_W−1; accumulation continues correctly.

## Configuration
- BITWISE_LOGIC_UNIT_PARITY_EN defined:
  - Adds output port y_parity (1 bit, = ^y).
  - It is registered with y, resets to 0 and holds under stall.
- Not defined: the port and its logic are absent. All other behaviour is identical.

## Test plan
- Reset, then each op with WIDTH=8, a=8'hCA, b=8'h0F, acc=0, out_ready=1:
  - y = 0A, CF, C5, F5, 30, 3A, C0, CA one cycle after each accept.
  - y_count=1 for every result.
- Zero/ones flags:
  - a=8'hFF, b=8'hFF, op=AND → y=FF, y_ones=1, y_zero=0.
  - op=XOR → y=00, y_zero=1, y_ones=0.
- Accumulate burst (op=AND throughout):
  - Beat 1 acc=1, last=0, a=FF, b=F0; beat 2 acc=1, last=0, b=3C; beat 3 acc=1, last=1, b=18.
  - Exactly one output: y=8'h10, y_count=3.
  - No out_valid after beats 1 and 2.
- Backpressure:
  - Hold out_ready=0 with out_valid=1 for 5 cycles while in_valid=1.
  - in_ready=0 and y stable throughout.
  - Raise out_ready → pending result consumed and next beat accepted on the same edge.
- Reset mid-burst:
  - Two acc=1 beats with op=OR, then assert rst_n=0 → outputs at reset values immediately.
  - After release, acc=1, last=1, a=8'h01, b=8'h02, op=OR → y=8'h03, y_count=1.
- Saturation and abort:
  - CNT_W=2 with 5-beat burst → y_count=3.
  - acc=0 beat mid-burst → standalone result; the following acc beat uses a, not acc_reg.
